alu_add_issue: RTL and testbench

ALU_ADD_ISSUE -- requirements
Module: alu_add_issue

---
 rtl/alu_add_issue_if.sv | 26 ++
 rtl/alu_add_issue.sv | 143 ++++++++++++++
 tb/tb_alu_add_issue.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_add_issue_if.sv
// Request/result handshake bundle for the add-issue stage.
// master drives requests and consumes results; slave is the issue block.
interface alu_add_issue_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/alu_add_issue.sv
// Issue stage for an external prefix adder: one-op issue register, sticky
// carry for ADC/SBC chains, and a 2-entry result FIFO with {Z,N,C,V} flags.
module alu_add_issue #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_add_issue_if.slave bus,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_cin,
  input  logic [W-1:0]   add_sum,
  input  logic           add_cout
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_INC = 3'b010,
    OP_DEC = 3'b011,
    OP_NEG = 3'b100,
    OP_CMP = 3'b101,
    OP_ADC = 3'b110,
    OP_SBC = 3'b111
  } op_e;

  localparam int unsigned EW = W + 4;

  logic          s1_valid;
  op_e           s1_op;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic          carry;

  logic          s1_adv;
  logic          in_accept;
  logic          push;
  logic          pop;
  logic          carry_upd;
  logic [W-1:0]  push_result;
  logic [3:0]    push_flags;

  logic [EW-1:0] fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_count;

  // Stage 1 may drain whenever the FIFO has room or is popping this cycle.
  assign s1_adv       = s1_valid && ((fifo_count < 2'd2) || bus.out_ready);
  assign bus.in_ready = rst_n && (!s1_valid || s1_adv);
  assign in_accept    = bus.in_valid && bus.in_ready;
  assign push         = s1_adv;
  assign pop          = (fifo_count != 2'd0) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_accept) begin
      s1_valid <= 1'b1;
      s1_op    <= op_e'(bus.in_op);
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (s1_valid) begin
      case (s1_op)
        OP_ADD: begin add_a = s1_a; add_b = s1_b;  add_cin = 1'b0;  end
        OP_SUB: begin add_a = s1_a; add_b = ~s1_b; add_cin = 1'b1;  end
        OP_INC: begin add_a = s1_a; add_b = '0;    add_cin = 1'b1;  end
        OP_DEC: begin add_a = s1_a; add_b = '1;    add_cin = 1'b0;  end
        OP_NEG: begin add_a = '0;   add_b = ~s1_a; add_cin = 1'b1;  end
        OP_CMP: begin add_a = s1_a; add_b = ~s1_b; add_cin = 1'b1;  end
        OP_ADC: begin add_a = s1_a; add_b = s1_b;  add_cin = carry; end
        OP_SBC: begin add_a = s1_a; add_b = ~s1_b; add_cin = carry; end
        default: begin add_a = '0;  add_b = '0;    add_cin = 1'b0;  end
      endcase
    end
  end

  always_comb begin
    push_flags[3] = (add_sum == '0);
    push_flags[2] = add_sum[W-1];
    push_flags[1] = add_cout;
    push_flags[0] = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
    push_result   = (s1_op == OP_CMP) ? '0 : add_sum;
  end

  always_comb begin
    carry_upd = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB, OP_CMP, OP_ADC, OP_SBC: carry_upd = 1'b1;
      default:                                carry_upd = 1'b0;
    endcase
  end

  // Only one op is ever in stage 1, so the next ADC/SBC always sees this update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (s1_adv && carry_upd) begin
      carry <= add_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {push_result, push_flags};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.out_valid  = (fifo_count != 2'd0);
  assign bus.out_result = fifo_mem[rd_ptr][EW-1:4];
  assign bus.out_flags  = fifo_mem[rd_ptr][3:0];

endmodule

// File: tb/tb_alu_add_issue.sv
// Bench for alu_add_issue: behavioural adder, arithmetic reference model and
// an in-order scoreboard of expected {result, flags}.
module tb_alu_add_issue;

  localparam int unsigned W = 32;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, INC = 3'b010, DEC = 3'b011,
                         NEG = 3'b100, CMP = 3'b101, ADC = 3'b110, SBC = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic [W:0]   add_full;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic model_c;
  bit   rnd_ready;

  always #5 clk = ~clk;

  alu_add_issue_if #(.W(W)) bus ();

  alu_add_issue #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum  = add_full[W-1:0];
  assign add_cout = add_full[W];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, output logic [31:0] res, output logic [3:0] fl,
                                 output logic nc);
    longint      ua, ub, sa, sb, ci, u, s;
    logic [31:0] r;
    logic        cy;
    logic        upd;
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    sa  = longint'({{32{a[31]}}, a});
    sb  = longint'({{32{b[31]}}, b});
    ci  = c ? 64'sd1 : 64'sd0;
    upd = 1'b1;
    u   = 0;
    case (op)
      ADD:      begin u = ua + ub; r = u[31:0]; cy = u[32]; s = sa + sb; end
      SUB, CMP: begin r = a - b; cy = (a >= b); s = sa - sb; end
      INC:      begin r = a + 32'd1; cy = (a == 32'hFFFF_FFFF); s = sa + 1; upd = 1'b0; end
      DEC:      begin r = a - 32'd1; cy = (a != 32'd0); s = sa - 1; upd = 1'b0; end
      NEG:      begin r = 32'd0 - a; cy = (a == 32'd0); s = -sa; upd = 1'b0; end
      ADC:      begin u = ua + ub + ci; r = u[31:0]; cy = u[32]; s = sa + sb + ci; end
      default:  begin r = a - b - 32'd1 + {31'b0, c}; cy = (ua + ci > ub); s = sa - sb - 1 + ci; end
    endcase
    fl  = {(r == 32'd0), r[31], cy, (s > 64'sd2147483647) || (s < -64'sd2147483648)};
    res = (op == CMP) ? 32'd0 : r;
    nc  = upd ? cy : c;
  endfunction

  function automatic logic [31:0] opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned budget;
    exp_t        e;
    logic        nc;
    @(negedge clk);
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    #2;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      #2;
      budget++;
    end
    if (bus.in_ready !== 1'b1) begin
      fail_now("accept");
    end else begin
      ref_op(op, a, b, model_c, e.res, e.fl, nc);
      model_c = nc;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    int unsigned budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      budget++;
    end
    if (sb_q.size() != 0) fail_now("drain");
  endtask

  // Scoreboard monitor: a transfer occurs at the next rising edge.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL spurious_out: observed result %0h expected no output", bus.out_result);
      end else begin
        e = sb_q.pop_front();
        chk("out_result", bus.out_result, e.res);
        chk("out_flags", bus.out_flags, e.fl);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    model_c       = 1'b0;
    rnd_ready     = 1'b0;

    repeat (2) @(negedge clk);
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_flags", bus.out_flags, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;

    // Wrap-around ADD and its one-cycle latency.
    send(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    chk("lat_s1_out_valid", bus.out_valid, 0);
    chk("lat_s1_add_a", add_a, 32'hFFFF_FFFF);
    chk("lat_s1_add_b", add_b, 32'h0000_0001);
    chk("lat_s1_add_cin", add_cin, 0);
    @(negedge clk);
    #2;
    chk("lat_out_valid", bus.out_valid, 1);
    drain();
    chk("empty_add_a", add_a, 0);
    chk("empty_add_cin", add_cin, 0);

    send(SUB, 32'h8000_0000, 32'h0000_0001);
    send(CMP, 32'd5, 32'd5);
    idle(1);
    drain();

    send(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    send(INC, 32'd7, 32'd0);
    send(ADC, 32'd1, 32'd2);
    idle(1);
    drain();

    send(NEG, 32'h8000_0000, 32'd0);
    send(DEC, 32'd0, 32'd0);
    send(SBC, 32'd16, 32'd3);
    send(INC, 32'h7FFF_FFFF, 32'd0);
    send(NEG, 32'd0, 32'd0);
    idle(1);
    drain();

    // Back-pressure: two in the FIFO, one in stage 1, fourth must stall.
    bus.out_ready = 1'b0;
    send(ADD, 32'd1, 32'd1);
    send(SUB, 32'd9, 32'd4);
    send(ADC, 32'd3, 32'd3);
    @(negedge clk);
    bus.in_op = SBC;
    bus.in_a  = 32'd20;
    bus.in_b  = 32'd5;
    #2;
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_out_result", bus.out_result, sb_q[0].res);
      chk("hold_out_flags", bus.out_flags, sb_q[0].fl);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    send(SBC, 32'd20, 32'd5);
    idle(1);
    drain();

    // Reset with a full pipeline and a set sticky carry.
    bus.out_ready = 1'b0;
    send(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    send(ADD, 32'hFFFF_FFFF, 32'h0000_0002);
    send(SBC, 32'd0, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    chk("prerst_out_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    model_c = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_out_result", bus.out_result, 0);
    chk("arst_add_a", add_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arel_in_ready", bus.in_ready, 1);
    chk("arel_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    send(ADC, 32'd1, 32'd1);
    idle(4);
    drain();

    // Random op stream with random output back-pressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      send(3'($urandom_range(0, 7)), opnd(), opnd());
    end
    idle(1);
    rnd_ready     = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
    drain();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
